keypad_scan_fifo: RTL and testbench

//  Parametrised matrix-keypad scanner: drives columns one-cold, samples active-low rows,

---
 rtl/keypad_scan_fifo.sv | 240 ++++++++++++++++++++++++
 tb/tb_keypad_scan_fifo.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scan_fifo.sv
// Matrix keypad scanner with single-key debounce and a first-word-fall-through
// key-code FIFO. Columns are driven one-cold and rows are sampled active-low
// once per column slot. One key is tracked at a time, and each press produces
// exactly one code.
//
// state    | meaning
// ---------+----------------------------------------------------------------
// SCAN     | rotating columns, waiting for any row low at a sample
// DEBOUNCE | column frozen, counting consecutive low samples of latched row
// HELD     | code pushed, column frozen, counting consecutive high samples
module keypad_scan_fifo #(
  parameter int ROWS           = 4,
  parameter int COLS           = 4,
  parameter int SCAN_DIV       = 2700,
  parameter int DEBOUNCE_SCANS = 4,
  parameter int FIFO_DEPTH     = 4,
  localparam int CW            = $clog2(ROWS * COLS),
  localparam int FW            = $clog2(FIFO_DEPTH) + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [ROWS-1:0] row_in,
  output logic [COLS-1:0] col_o,
  output logic [CW-1:0]   key_code,
  output logic            key_valid,
  input  logic            key_ready,
  output logic [FW-1:0]   fifo_count,
  output logic            overflow,
  input  logic            clear
);

  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int KW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int DW = $clog2(SCAN_DIV);
  localparam int NW = $clog2(DEBOUNCE_SCANS + 1);
  localparam int PW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] div_q;
  logic [KW-1:0] col_q, col_d, col_adv;
  logic [NW-1:0] cnt_q, cnt_d;
  logic [RW-1:0] lat_row_q, lat_row_d;
  logic [RW-1:0] hit_row, push_row;
  logic          any_low;
  logic          sample;
  logic          cnt_last;
  logic          push;
  logic [CW-1:0] push_code;

  logic [CW-1:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [FW-1:0] count_q, count_d;
  logic [CW-1:0] head_d;
  logic          pop, full, push_ok, drop;

  assign sample   = (div_q == DW'(SCAN_DIV - 1));
  assign cnt_last = (cnt_q == NW'(DEBOUNCE_SCANS - 1));
  assign col_adv  = (col_q == KW'(COLS - 1)) ? '0 : col_q + KW'(1);
  assign push_code = CW'(32'(push_row) * 32'(COLS) + 32'(col_q));

  // Slot divider: free-running 0..SCAN_DIV-1, the last count is the sample point.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_q <= '0;
    end else if (sample) begin
      div_q <= '0;
    end else begin
      div_q <= div_q + DW'(1);
    end
  end

  // Lowest-index low row wins when several rows are pressed on one column.
  always_comb begin
    any_low = 1'b0;
    hit_row = '0;
    for (int i = ROWS - 1; i >= 0; i--) begin
      if (!row_in[i]) begin
        any_low = 1'b1;
        hit_row = RW'(i);
      end
    end
  end

  // Column drive: exactly one column low.
  always_comb begin
    col_o        = '1;
    col_o[col_q] = 1'b0;
  end

  // Scanner state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= SCAN;
      col_q     <= '0;
      cnt_q     <= '0;
      lat_row_q <= '0;
    end else begin
      state_q   <= state_d;
      col_q     <= col_d;
      cnt_q     <= cnt_d;
      lat_row_q <= lat_row_d;
    end
  end

  // Scanner next state; everything only moves on a sample cycle.
  always_comb begin
    state_d   = state_q;
    col_d     = col_q;
    cnt_d     = cnt_q;
    lat_row_d = lat_row_q;
    push      = 1'b0;
    push_row  = lat_row_q;
    if (sample) begin
      case (state_q)
        SCAN: begin
          if (any_low) begin
            lat_row_d = hit_row;
            push_row  = hit_row;
            if (DEBOUNCE_SCANS == 1) begin
              push    = 1'b1;
              cnt_d   = '0;
              state_d = HELD;
            end else begin
              cnt_d   = NW'(1);
              state_d = DEBOUNCE;
            end
          end else begin
            col_d = col_adv;
          end
        end
        DEBOUNCE: begin
          if (!row_in[lat_row_q]) begin
            if (cnt_last) begin
              push    = 1'b1;
              cnt_d   = '0;
              state_d = HELD;
            end else begin
              cnt_d = cnt_q + NW'(1);
            end
          end else begin
            cnt_d   = '0;
            col_d   = col_adv;
            state_d = SCAN;
          end
        end
        HELD: begin
          if (row_in[lat_row_q]) begin
            if (cnt_last) begin
              cnt_d   = '0;
              col_d   = col_adv;
              state_d = SCAN;
            end else begin
              cnt_d = cnt_q + NW'(1);
            end
          end else begin
            cnt_d = '0;
          end
        end
        default: begin
          cnt_d   = '0;
          state_d = SCAN;
        end
      endcase
    end
  end

  // A push into a full FIFO still succeeds when the head is popped that cycle.
  assign pop        = key_valid && key_ready;
  assign full       = (count_q == FW'(FIFO_DEPTH));
  assign push_ok    = push && (!full || pop);
  assign drop       = push && full && !pop;
  assign fifo_count = count_q;

  // Occupancy after this cycle's push/pop.
  always_comb begin
    count_d = count_q;
    case ({push_ok, pop})
      2'b10:   count_d = count_q + FW'(1);
      2'b01:   count_d = count_q - FW'(1);
      default: count_d = count_q;
    endcase
  end

  // Next head: the registered key_code is kept one step ahead of the storage.
  always_comb begin
    head_d = key_code;
    if (pop) begin
      if (count_q == FW'(1)) begin
        if (push_ok) begin
          head_d = push_code;
        end
      end else begin
        head_d = mem_q[rd_ptr_q + PW'(1)];
      end
    end else if ((count_q == '0) && push_ok) begin
      head_d = push_code;
    end
  end

  // Storage array needs no reset; occupancy and the head register qualify it.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= push_code;
    end
  end

  // FIFO pointers, occupancy, registered head and sticky overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      key_code  <= '0;
      key_valid <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr_q <= wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end
      count_q   <= count_d;
      key_valid <= (count_d != '0);
      key_code  <= head_d;
      if (drop) begin
        overflow <= 1'b1;
      end else if (clear) begin
        overflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_keypad_scan_fifo.sv
// Directed bench for keypad_scan_fifo with a behavioural single-key keypad.
module tb_keypad_scan_fifo;

  logic       clk;
  logic       rst;
  logic [3:0] row_in;
  logic [3:0] col_o;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_ready;
  logic [2:0] fifo_count;
  logic       overflow;
  logic       clear;

  logic       key_on;
  logic [1:0] kr;
  logic [1:0] kc;

  int n_checks;
  int n_fail;

  keypad_scan_fifo #(
    .ROWS          (4),
    .COLS          (4),
    .SCAN_DIV      (4),
    .DEBOUNCE_SCANS(3),
    .FIFO_DEPTH    (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .row_in    (row_in),
    .col_o     (col_o),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_ready (key_ready),
    .fifo_count(fifo_count),
    .overflow  (overflow),
    .clear     (clear)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Keypad: the pressed key pulls its row low only while its column is driven.
  always_comb begin
    row_in = '1;
    if (key_on && !col_o[kc]) begin
      row_in[kr] = 1'b0;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance n rising edges, then settle on the following falling edge.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic press_release(input logic [1:0] r, input logic [1:0] c);
    kr     = r;
    kc     = c;
    key_on = 1'b1;
    tick(48);
    key_on = 1'b0;
    tick(32);
  endtask

  task automatic pop_one();
    key_ready = 1'b1;
    tick(1);
    key_ready = 1'b0;
  endtask

  // Stop on the falling edge right after column 0 becomes driven (slot start).
  task automatic wait_col0();
    int n;
    n = 0;
    while (col_o == 4'b1110 && n < 64) begin
      tick(1);
      n++;
    end
    while (col_o != 4'b1110 && n < 64) begin
      tick(1);
      n++;
    end
    check_eq("wait_col0_in_time", 32'(n < 64), 32'd1);
  endtask

  logic [3:0] exp_col [4];
  logic [3:0] exp_q4  [4];
  logic [3:0] exp_q5  [4];

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    rst       = 1'b1;
    key_ready = 1'b0;
    clear     = 1'b0;
    key_on    = 1'b0;
    kr        = 2'd0;
    kc        = 2'd0;
    exp_col   = '{4'b1101, 4'b1011, 4'b0111, 4'b1110};
    exp_q4    = '{4'd0, 4'd5, 4'd10, 4'd15};
    exp_q5    = '{4'd2, 4'd4, 4'd8, 4'd9};

    // 1: reset values and idle column rotation
    tick(5);
    check_eq("rst_col_o", 32'(col_o), 32'hE);
    check_eq("rst_key_valid", 32'(key_valid), 32'd0);
    check_eq("rst_fifo_count", 32'(fifo_count), 32'd0);
    check_eq("rst_overflow", 32'(overflow), 32'd0);
    check_eq("rst_key_code", 32'(key_code), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick(4);
      check_eq("rotate_col_o", 32'(col_o), 32'(exp_col[i]));
    end

    // 2: held key r1 c2, detected 12 edges in, pushed 8 edges after that
    kr     = 2'd1;
    kc     = 2'd2;
    key_on = 1'b1;
    tick(19);
    check_eq("hold_valid_early", 32'(key_valid), 32'd0);
    check_eq("hold_count_early", 32'(fifo_count), 32'd0);
    tick(1);
    check_eq("hold_valid", 32'(key_valid), 32'd1);
    check_eq("hold_code", 32'(key_code), 32'd6);
    check_eq("hold_count", 32'(fifo_count), 32'd1);
    check_eq("hold_col_frozen", 32'(col_o), 32'hB);
    tick(180);
    check_eq("hold_no_repeat", 32'(fifo_count), 32'd1);
    key_on = 1'b0;
    tick(11);
    check_eq("release_col_wait", 32'(col_o), 32'hB);
    tick(1);
    check_eq("release_col_adv", 32'(col_o), 32'h7);
    pop_one();
    check_eq("pop_count", 32'(fifo_count), 32'd0);
    check_eq("pop_valid", 32'(key_valid), 32'd0);

    // 3: bounce on r3 c0 for a single sample
    wait_col0();
    kr     = 2'd3;
    kc     = 2'd0;
    key_on = 1'b1;
    tick(4);
    check_eq("bounce_col_frozen", 32'(col_o), 32'hE);
    key_on = 1'b0;
    tick(4);
    check_eq("bounce_col_adv", 32'(col_o), 32'hD);
    check_eq("bounce_count", 32'(fifo_count), 32'd0);
    check_eq("bounce_valid", 32'(key_valid), 32'd0);

    // 4: fill, overflow, ordered drain, clear
    press_release(2'd0, 2'd0);
    press_release(2'd1, 2'd1);
    press_release(2'd2, 2'd2);
    press_release(2'd3, 2'd3);
    check_eq("fill_count", 32'(fifo_count), 32'd4);
    check_eq("fill_no_ovf", 32'(overflow), 32'd0);
    press_release(2'd0, 2'd3);
    check_eq("ovf_count", 32'(fifo_count), 32'd4);
    check_eq("ovf_set", 32'(overflow), 32'd1);
    for (int i = 0; i < 4; i++) begin
      check_eq("drain4_valid", 32'(key_valid), 32'd1);
      check_eq("drain4_code", 32'(key_code), 32'(exp_q4[i]));
      pop_one();
    end
    check_eq("drain4_empty", 32'(fifo_count), 32'd0);
    check_eq("ovf_sticky", 32'(overflow), 32'd1);
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    check_eq("ovf_cleared", 32'(overflow), 32'd0);

    // 5: push into full FIFO with a pop in the same cycle
    press_release(2'd0, 2'd1);
    press_release(2'd0, 2'd2);
    press_release(2'd1, 2'd0);
    press_release(2'd2, 2'd0);
    check_eq("full5_count", 32'(fifo_count), 32'd4);
    check_eq("full5_head", 32'(key_code), 32'd1);
    wait_col0();
    kr     = 2'd2;
    kc     = 2'd1;
    key_on = 1'b1;
    tick(15);
    key_ready = 1'b1;
    tick(1);
    key_ready = 1'b0;
    check_eq("pushpop_count", 32'(fifo_count), 32'd4);
    check_eq("pushpop_no_ovf", 32'(overflow), 32'd0);
    check_eq("pushpop_head", 32'(key_code), 32'd2);
    tick(40);
    key_on = 1'b0;
    tick(32);
    for (int i = 0; i < 4; i++) begin
      check_eq("drain5_code", 32'(key_code), 32'(exp_q5[i]));
      pop_one();
    end
    check_eq("drain5_empty", 32'(fifo_count), 32'd0);

    // 6: reset during DEBOUNCE with two entries queued
    press_release(2'd1, 2'd3);
    press_release(2'd3, 2'd0);
    check_eq("pre_rst_count", 32'(fifo_count), 32'd2);
    check_eq("pre_rst_head", 32'(key_code), 32'd7);
    wait_col0();
    kr     = 2'd2;
    kc     = 2'd2;
    key_on = 1'b1;
    tick(13);
    check_eq("deb_col_frozen", 32'(col_o), 32'hB);
    rst = 1'b1;
    tick(1);
    check_eq("mid_rst_col_o", 32'(col_o), 32'hE);
    check_eq("mid_rst_valid", 32'(key_valid), 32'd0);
    check_eq("mid_rst_count", 32'(fifo_count), 32'd0);
    check_eq("mid_rst_overflow", 32'(overflow), 32'd0);
    check_eq("mid_rst_code", 32'(key_code), 32'd0);
    rst = 1'b0;
    tick(19);
    check_eq("rerun_count_early", 32'(fifo_count), 32'd0);
    tick(1);
    check_eq("rerun_count", 32'(fifo_count), 32'd1);
    check_eq("rerun_valid", 32'(key_valid), 32'd1);
    check_eq("rerun_code", 32'(key_code), 32'd10);
    tick(100);
    check_eq("rerun_once", 32'(fifo_count), 32'd1);
    key_on = 1'b0;
    tick(32);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
